// File: rtl/pp_final_cpa_seq.sv
// -----------------------------------------------------------------------------
// pp_final_cpa_seq
//
// Multi-cycle final carry-propagate adder for a multiplier. Takes the two rows
// left by the partial-product reduction tree and produces
//   res = (pp1 + (pp2 << 1)) mod 2^W,  W = 2*Bitwidth
// adding one CHUNK-bit slice per clock. The inter-slice carry is registered, so
// the longest combinational path is a single CHUNK-bit adder.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   pp1/pp2 valid                 (handshake with reduction tree)
//   in_ready   block can accept a new pair   (only in IDLE and out of reset)
//   pp1        sum row, weight x1
//   pp2        carry row, weight x2
//   out_valid  res/ovf valid                 (handshake with result register)
//   out_ready  downstream accepts res
//   res        (pp1 + (pp2<<1)) mod 2^W
//   ovf        true sum >= 2^W
//   busy       FSM not in IDLE
// -----------------------------------------------------------------------------
module pp_final_cpa_seq #(
  parameter int Bitwidth = 8,
  parameter int CHUNK    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*Bitwidth-1:0]   pp1,
  input  logic [2*Bitwidth-1:0]   pp2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*Bitwidth-1:0]   res,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W    = 2 * Bitwidth;
  localparam int NCH  = W / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  // The slice width must tile the result exactly.
  if (CHUNK < 1) begin : g_bad_chunk_zero
    $error("pp_final_cpa_seq: CHUNK must be >= 1");
  end else if ((W % CHUNK) != 0) begin : g_bad_chunk_div
    $error("pp_final_cpa_seq: CHUNK must divide 2*Bitwidth");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            drop_q, drop_d;
  logic [W-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;

  // Operands are kept as right-shifting registers: the slice being added is
  // always in the low CHUNK bits, so no variable-index mux sits in front of
  // the adder.
  logic [CHUNK:0]  sum_w;
  logic            last_chunk;
  logic [W-1:0]    res_ins;

  assign sum_w = {1'b0, a_q[CHUNK-1:0]}
               + {1'b0, b_q[CHUNK-1:0]}
               + (CHUNK+1)'(carry_q);

  assign last_chunk = (idx_q == IDXW'(NCH - 1));

  // res with the current slice replaced by the fresh sum; other slices hold.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign res_ins[gi*CHUNK +: CHUNK] = (idx_q == IDXW'(gi))
                                      ? sum_w[CHUNK-1:0]
                                      : res_q[gi*CHUNK +: CHUNK];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    drop_d  = drop_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = pp1;
          // pp2 carries weight 2; its top bit leaves the W-bit window and only
          // contributes to the overflow flag.
          b_d     = {pp2[W-2:0], 1'b0};
          drop_d  = pp2[W-1];
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum_w[CHUNK];
        res_d   = res_ins;
        if (last_chunk) begin
          ovf_d   = sum_w[CHUNK] | drop_q;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      drop_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      drop_q  <= drop_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ready is withheld while reset is asserted so nothing is accepted on an
  // edge that reset will override anyway.
  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pp_final_cpa_seq.sv
// -----------------------------------------------------------------------------
// tb_pp_final_cpa_seq
//
// Three independent lanes (CHUNK = 4, 8, 16 with Bitwidth = 8), each with its
// own DUT, driver, out_ready generator and monitor. Expected results come from
// plain arithmetic (pp1 + 2*pp2 split at bit W) pushed into a queue when an
// operand pair is accepted; the monitor pops and compares on every output
// handshake and also checks latency, hold-stability under backpressure and
// the IDLE cycle after each handshake.
// -----------------------------------------------------------------------------
module tb_pp_final_cpa_seq;

  localparam int BW = 8;
  localparam int W  = 2 * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit lane_done [3];

  task automatic check(input int c, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL chunk=%0d %s: got 0x%0h expected 0x%0h", c, nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam int C   = 4 << gi;
    localparam int NCH = W / C;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] pp1       = '0;
    logic [W-1:0] pp2       = '0;
    logic         in_ready, out_valid, ovf, busy;
    logic [W-1:0] res;

    int cyc     = 0;
    bit mon_en  = 1'b0;
    int or_mode = 0;   // 0: always ready, 1: random stalls, 2: held low

    logic [W-1:0] exp_res_q [$];
    logic         exp_ovf_q [$];
    int           acc_q     [$];

    pp_final_cpa_seq #(.Bitwidth(BW), .CHUNK(C)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pp1      (pp1),
      .pp2      (pp2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res      (res),
      .ovf      (ovf),
      .busy     (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end

    // Reference: full-precision sum, low W bits are res, anything above is ovf.
    task automatic model_push(input logic [W-1:0] p1, input logic [W-1:0] p2);
      logic [W+1:0] full;
      full = (W+2)'(p1) + ((W+2)'(p2) * 2);
      exp_res_q.push_back(full[W-1:0]);
      exp_ovf_q.push_back(full >= (W+2)'(1 << W));
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [W-1:0] p1, input logic [W-1:0] p2, input bit push);
      int n;
      bit ok;
      pp1 = p1; pp2 = p2; in_valid = 1'b1;
      n = 0; ok = 1'b0;
      while (!ok && n < 500) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        n++;
      end
      if (!ok) check(C, "accept_timeout", 0, 1);
      else if (push) begin
        model_push(p1, p2);
        acc_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      pp1 = W'($urandom);
      pp2 = W'($urandom);
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_res_q.size() != 0 || busy) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) check(C, "drain_timeout", 1, 0);
      @(posedge clk); #1;
    endtask

    // Monitor
    initial begin : mon
      logic         pv, phs, povf;
      logic [W-1:0] pres;
      int           lat;
      pv = 1'b0; phs = 1'b0; povf = 1'b0; pres = '0;
      forever begin
        @(negedge clk);
        if (mon_en && rst_n) begin
          if (phs) check(C, "idle_after_hs{in_ready,out_valid}",
                         32'({in_ready, out_valid}), 32'h2);
          if (out_valid && !pv) begin
            if (acc_q.size() == 0) check(C, "valid_without_accept", 1, 0);
            else begin
              lat = cyc - acc_q.pop_front();
              check(C, "latency", 32'(lat), 32'(NCH));
            end
          end
          if (out_valid && pv && !phs) begin
            check(C, "stall_res_stable", 32'(res), 32'(pres));
            check(C, "stall_ovf_stable", 32'(ovf), 32'(povf));
          end
          if (out_valid) begin
            check(C, "in_ready_in_done", 32'(in_ready), 0);
            check(C, "busy_in_done", 32'(busy), 1);
          end
          if (out_valid && out_ready) begin
            if (exp_res_q.size() == 0) check(C, "unexpected_output", 1, 0);
            else begin
              check(C, "res", 32'(res), 32'(exp_res_q.pop_front()));
              check(C, "ovf", 32'(ovf), 32'(exp_ovf_q.pop_front()));
            end
          end
          phs  = out_valid && out_ready;
          pv   = out_valid && !out_ready;
          pres = res;
          povf = ovf;
        end else begin
          pv = 1'b0; phs = 1'b0;
        end
      end
    end

    // Stimulus
    initial begin : drv
      int           n;
      logic [W-1:0] p1, p2;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(C, "rst_out_valid", 32'(out_valid), 0);
      check(C, "rst_busy",      32'(busy), 0);
      check(C, "rst_res",       32'(res), 0);
      check(C, "rst_ovf",       32'(ovf), 0);
      check(C, "rst_in_ready",  32'(in_ready), 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      or_mode = 0;

      // Directed arithmetic cases
      send(16'h00FF, 16'h0001, 1'b1);
      send(16'hFFFF, 16'h0001, 1'b1);
      send(16'h0000, 16'h8000, 1'b1);
      send(16'h1234, 16'h0000, 1'b1);
      wait_drain();

      // Backpressure with a new pair waiting
      or_mode = 2;
      send(16'h1111, 16'h2222, 1'b1);
      fork
        send(16'h0003, 16'h0002, 1'b1);
        begin
          n = 0;
          while (!out_valid && n < 100) begin @(negedge clk); n++; end
          if (n >= 100) check(C, "bp_valid_timeout", 0, 1);
          repeat (10) @(negedge clk);
          or_mode = 0;
        end
      join
      wait_drain();

      // Reset in the middle of an operation
      mon_en  = 1'b0;
      or_mode = 2;
      send(16'hABCD, 16'h1357, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check(C, "in_ready_during_reset", 32'(in_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check(C, "midrst_out_valid", 32'(out_valid), 0);
      check(C, "midrst_busy",      32'(busy), 0);
      check(C, "midrst_res",       32'(res), 0);
      check(C, "midrst_ovf",       32'(ovf), 0);
      check(C, "midrst_in_ready",  32'(in_ready), 1);
      or_mode = 0;
      mon_en  = 1'b1;
      @(posedge clk); #1;
      send(16'h0010, 16'h0008, 1'b1);
      wait_drain();

      // Random traffic with random output stalls
      or_mode = 1;
      for (int i = 0; i < 2000; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        p1 = W'($urandom);
        p2 = W'($urandom);
        if ($urandom_range(0, 7) == 0) p1 = '1;
        if ($urandom_range(0, 7) == 0) p2 = {1'b1, {(W-1){1'b0}}};
        send(p1, p2, 1'b1);
      end
      wait_drain();
      check(C, "scoreboard_empty", 32'(exp_res_q.size() + acc_q.size()), 0);
      lane_done[gi] = 1'b1;
    end
  end

  initial begin : main
    int n;
    n = 0;
    while (!(lane_done[0] && lane_done[1] && lane_done[2]) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 90000) check(0, "global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
